// File: rtl/csa_accum_ctrl_if.sv
// csa_accum_ctrl_if: operand-in / result-out handshake bundle for csa_accum_ctrl
interface csa_accum_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int RES_W = 11
);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [RES_W-1:0] res;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, res);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, res);
endinterface

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: sums N_OPS unsigned operands per batch through a carry-save accumulator
module csa_accum_ctrl #(
  parameter int DATA_W = 8,
  parameter int N_OPS = 8,
  localparam int RES_W = DATA_W + $clog2(N_OPS),
  localparam int CW = $clog2(N_OPS) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  csa_accum_ctrl_if.slave bus,
  output logic [CW-1:0] op_cnt,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
  state_t state, state_n;
  logic [RES_W-1:0] sum_r, carry_r, sum_n, carry_n, a, b, c, res_r;
  logic xfer, last;
  assign xfer = bus.in_valid && bus.in_ready;
  assign last = op_cnt == CW'(N_OPS - 1);
  assign bus.in_ready = state != OUT;
  assign bus.out_valid = state == OUT;
  assign bus.res = res_r;
  assign busy = state != IDLE;
  // carry_r is stored unshifted; the weight-2 alignment happens at use
  always_comb begin
    a = sum_r;
    b = carry_r << 1;
    c = {{(RES_W-DATA_W){1'b0}}, bus.in_data};
    sum_n = a ^ b ^ c;
    carry_n = (a & b) | (a & c) | (b & c);
    state_n = clear ? IDLE
            : (state == IDLE && xfer) ? ACC
            : (state == ACC && xfer && last) ? OUT
            : (state == OUT && bus.out_ready) ? IDLE
            : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sum_r <= '0;
      carry_r <= '0;
      op_cnt <= '0;
      res_r <= '0;
    end else begin
      state <= state_n;
      if (clear || (state == OUT && bus.out_ready)) begin
        sum_r <= '0;
        carry_r <= '0;
        op_cnt <= '0;
      end else if (xfer) begin
        sum_r <= sum_n;
        carry_r <= carry_n;
        op_cnt <= op_cnt + 1'b1;
        if (last) res_r <= sum_n + (carry_n << 1);
      end
    end
  end
endmodule

// File: doc/csa_accum_ctrl.md
CSA_ACCUM_CTRL -- requirements
Module: csa_accum_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning operand width in bits (>= 2).
REQ-002 SHALL have parameter N_OPS, default 8, meaning operands summed per batch (>= 2).
REQ-003 SHALL have derived localparam RES_W = DATA_W + $clog2(N_OPS), meaning result width.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset; asynchronous, active-low.
REQ-006 SHALL have port clear, input, 1, meaning synchronous batch abort.
REQ-007 SHALL have port in_valid, input, 1, meaning in_data holds an operand.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts an operand this cycle.
REQ-009 SHALL have port in_data, input, DATA_W, meaning unsigned operand.
REQ-010 SHALL have port out_valid, output, 1, meaning res holds a completed batch sum.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes res this cycle.
REQ-012 SHALL have port res, output, RES_W, meaning unsigned sum of the batch.
REQ-013 SHALL have port op_cnt, output, $clog2(N_OPS)+1, meaning operands accepted in the current batch.
REQ-014 SHALL have port busy, output, 1, meaning at least one operand has been accepted and the result is not yet consumed.

Function
REQ-015 SHALL implement a three-state FSM: IDLE (op_cnt = 0), ACC (0 < op_cnt < N_OPS), OUT (result held).
REQ-016 SHALL drive in_ready = 1 in IDLE and ACC and 0 in OUT; an operand transfers when in_valid && in_ready.
REQ-017 SHALL keep running carry-save state (sum_r, carry_r, RES_W bits each) and update it per transfer through a 3:2 carry-save compressor with inputs sum_r, carry_r << 1, and zero-extended in_data.
REQ-018 SHALL leave sum_r, carry_r and op_cnt unchanged in any cycle without a transfer, including in_valid gaps.
REQ-019 SHALL increment op_cnt on each transfer; the transfer in IDLE moves the FSM to ACC.
REQ-020 SHALL, on the transfer that makes op_cnt = N_OPS, register res = resolved carry-propagate sum of the updated carry-save pair, move to OUT and assert out_valid on the next cycle (latency 1 cycle after the last operand).
REQ-021 SHALL hold res and out_valid stable in OUT until out_valid && out_ready; on that cycle it SHALL return to IDLE, clear sum_r/carry_r/op_cnt, and deassert out_valid next cycle.
REQ-022 SHALL make res exactly equal the arithmetic sum of the N_OPS operands; with RES_W as defined, no overflow is possible.
REQ-023 SHALL accept no operand in OUT, so there is no same-cycle overlap of the last result hand-off and the next batch's first operand; the first operand of the next batch is accepted no earlier than the cycle after the hand-off.
REQ-024 SHALL, when clear = 1, return to IDLE on the next edge with sum_r = carry_r = 0, op_cnt = 0, out_valid = 0, discarding any partial batch or held result; clear takes priority over a simultaneous transfer or hand-off.
REQ-025 SHALL drive busy = 1 whenever the FSM is in ACC or OUT, else 0.
REQ-026 SHALL treat N_OPS = 2 identically: the first transfer moves IDLE -> ACC and the second moves ACC -> OUT.

Reset
REQ-027 SHALL, while rst_n = 0, force FSM = IDLE, sum_r = carry_r = 0, op_cnt = 0, res = 0, out_valid = 0 and busy = 0, independent of clk.
REQ-028 SHALL drive in_ready = 1 from the first cycle after rst_n deasserts.
REQ-029 SHALL discard any partial batch or held result when reset asserts mid-operation; no result of that batch is ever presented.

Verification
REQ-030 SHALL cover all-max input: DATA_W = 8, N_OPS = 8, eight transfers of 8'hFF back-to-back -> out_valid one cycle after the 8th transfer, res = 11'd2040, op_cnt = 8.
REQ-031 SHALL cover a random scoreboard: 1000 batches of $random operands with random in_valid gaps and random out_ready -> every res equals a behavioural + sum of its batch, and no operand is lost or duplicated.
REQ-032 SHALL cover backpressure: batch 1..8 (sum 36) with out_ready = 0 for 5 cycles -> res = 36 and out_valid stay stable, in_ready = 0 throughout; hand-off on the first out_ready = 1 cycle, then in_ready = 1.
REQ-033 SHALL cover clear mid-batch: three operands of 10, then clear, then eight operands of 1 -> res = 8, and op_cnt = 0 in the cycle after clear.
REQ-034 SHALL cover async reset mid-batch and in OUT: rst_n pulsed low between clock edges -> outputs reach reset values immediately, and the following full batch of 8'h01 gives res = 8.
REQ-035 SHALL cover N_OPS = 2: operands 8'hFF and 8'h01 -> res = 9'd256 one cycle after the second transfer.
